instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the decode/immediate-extend path of the RV32I core. Owns the fetch PC and
//  issues in-order word reads to instruction memory over a req/gnt/rvalid handshake. Buffers
//  returned words in a small FIFO and presents {inst, pc} to decode with valid/ready.
//  Branch/jump redirect flushes all in-flight and buffered work.
// PARAMETERS
//  RESET_PC     32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH   2              instruction buffer entries (power of 2, >=2)
// PORTS
//  clk           in   1   core clock, all state on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  imem_req      out  1   read request valid
//  imem_addr     out  32  word-aligned read address
//  imem_gnt      in   1   request accepted this cycle
//  imem_rvalid   in   1   read data valid (in order, >=1 cycle after gnt)
//  imem_rdata    in   32  instruction word
//  redirect      in   1   taken branch/jump: restart fetch
//  redirect_pc   in   32  new fetch target
//  if_valid      out  1   if_inst/if_pc valid to decode
//  if_ready      in   1   decode accepts this cycle
//  if_inst       out  32  instruction word (bits [31:7] drive immediate extend)
//  if_pc         out  32  address of if_inst
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): fetch_pc=RESET_PC, FIFO empty, outstanding=0,
//    discard=0; imem_req=0, imem_addr=RESET_PC, if_valid=0, if_inst=32'h0000_0013, if_pc=RESET_PC.
//  - Credit: imem_req=1 iff !redirect && (outstanding + fifo_count) < FIFO_DEPTH && discard==0.
//  - imem_addr=fetch_pc. On imem_req&&imem_gnt: fetch_pc+=4 (wraps mod 2^32), outstanding+=1,
//    tag FIFO-bound pc queue with fetch_pc. No commitment before gnt.
//  - imem_rvalid: if discard>0, drop word, discard-=1; else push {rdata, pc}, outstanding-=1.
//    gnt and rvalid in same cycle: net outstanding unchanged.
//  - Output: if_valid = FIFO non-empty; pop on if_valid&&if_ready. Push+pop same cycle allowed at
//    any occupancy; credit rule guarantees no overflow. No combinational rdata->if_inst bypass:
//    fetch-to-decode latency = 1 cycle after rvalid.
//  - Redirect (priority over everything): FIFO flushed, pop ignored, fetch_pc<=redirect_pc,
//    imem_req=0 that cycle, discard<=outstanding - (rvalid this cycle ? 1 : 0) + discard
//    contribution, outstanding<=0. Fetching resumes next cycle once discard==0.
//  - redirect_pc[1:0] ignored for addressing (imem_addr[1:0] forced 2'b00).
//  - Reset mid-transaction: all counters cleared; late rvalid after reset with outstanding==0 is
//    ignored.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: adds output if_misalign (1 bit, reset 0). A redirect with
//    redirect_pc[1:0]!=0 sets a sticky flag; no imem_req issued while set. if_misalign=1 with
//    if_valid=1, if_pc=redirect_pc, if_inst=32'h0000_0013 until accepted. A later redirect clears
//    the flag.
//  Undefined: no port, no check, low bits silently dropped.
// STRUCTURE
//  Package rv32_fetch_pkg: XLEN=32, ILEN=32, NOP_INST=32'h0000_0013, PC_STEP=4,
//    typedef struct packed {logic [31:0] inst; logic [31:0] pc;} fetch_entry_t.
//  Sub-module fetch_fifo (parameterised depth, fetch_entry_t payload, push/pop/flush, count).
//  Top level holds PC register, outstanding/discard counters, in-flight pc queue, credit logic.
// TESTING
//  1 Reset, imem_gnt=1, rdata=k*4 after 1 cycle -> requests at 0x0,0x4,0x8; if_pc/if_inst stream
//    0x0,0x4,0x8 in order, back-to-back when if_ready=1.
//  2 if_ready=0 for 10 cycles -> at most FIFO_DEPTH entries buffered, imem_req drops to 0, no
//    word lost; release -> stream resumes at next pc.
//  3 Two outstanding grants, redirect to 0x100 -> both late rvalid words dropped; first if_pc
//    after redirect = 0x100.
//  4 Redirect in same cycle as rvalid and if_ready -> no pop, that word dropped, next if_pc=target.
//  5 Stall imem_gnt=0 for 5 cycles with imem_req=1 -> imem_addr stable, fetch_pc not advanced.
//  6 FETCH_MISALIGN_CHECK_EN: redirect to 0x102 -> if_misalign=1, if_pc=0x102, no imem_req;
//    redirect to 0x200 clears it and fetches 0x200.

Source files
------------

// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
//   XLEN/ILEN     : address and instruction widths
//   NOP_INST      : addi x0,x0,0, presented whenever no real instruction is available
//   PC_STEP       : sequential fetch increment
//   fetch_entry_t : {inst, pc} pair buffered between fetch and decode
package rv32_fetch_pkg;

  localparam int unsigned      XLEN     = 32;
  localparam int unsigned      ILEN     = 32;
  localparam logic [ILEN-1:0]  NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0]  PC_STEP  = 32'd4;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus (req/gnt request phase, in-order rvalid response phase).
//   req    : read request valid          (master -> slave)
//   addr   : word-aligned read address   (master -> slave)
//   gnt    : request accepted this cycle (slave -> master)
//   rvalid : read data valid             (slave -> master)
//   rdata  : instruction word            (slave -> master)
interface instr_fetch_unit_if;
  import rv32_fetch_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [ILEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : drop all entries; overrides push and pop
//   push_i        : write push_data_i at the tail
//   pop_i         : remove the head entry (ignored when empty)
//   head_o        : head entry, valid when !empty_o
//   empty_o       : no entries buffered
//   count_o       : number of entries buffered
// Depth must be a power of two so the pointers wrap for free. Push while full is only legal
// together with a pop; the caller's credit scheme guarantees this.
module fetch_fifo
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned  Depth = 2,
  localparam int unsigned Aw    = $clog2(Depth),
  localparam int unsigned Cw    = Aw + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         empty_o,
  output logic [Cw-1:0] count_o
);

  fetch_entry_t  mem_q [Depth];
  logic [Aw-1:0] wptr_q, rptr_q;
  logic [Cw-1:0] count_q;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push_i && !flush_i;
    do_pop  = pop_i && !flush_i && (count_q != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + Aw'(1);
      if (do_pop)  rptr_q <= rptr_q + Aw'(1);
      count_q <= count_q + Cw'(do_push) - Cw'(do_pop);
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the fetch PC, issues in-order word reads to instruction memory and
// buffers returned words for decode.
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem         : instruction memory bus (instr_fetch_unit_if.master)
//   redirect     : taken branch/jump, flushes all in-flight and buffered work
//   redirect_pc  : new fetch target (low two bits not used for addressing)
//   if_valid     : if_inst/if_pc valid to decode
//   if_ready     : decode accepts this cycle
//   if_inst      : instruction word (NOP when nothing is buffered)
//   if_pc        : address of if_inst
//   if_misalign  : only with FETCH_MISALIGN_CHECK_EN defined; flags a misaligned redirect target
// Build option FETCH_MISALIGN_CHECK_EN: a misaligned redirect blocks fetching and presents a
// NOP at the misaligned pc with if_misalign set until decode accepts it.
module instr_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master imem,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ILEN-1:0]    if_inst,
  output logic [XLEN-1:0]    if_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic               if_misalign
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  // pc of every granted but not yet returned request, oldest at rptr
  logic [XLEN-1:0] pcq_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   pcq_wptr_q, pcq_rptr_q;

  logic            grant, rsp_take, rsp_drop, rsp_pending;
  logic            credit_ok, fetch_block;
  logic [CW:0]     inflight;

  fetch_entry_t    fifo_push_data, fifo_head;
  logic            fifo_empty, fifo_pop;
  logic [CW-1:0]   fifo_count;

  // ---------------------------------------------------------------------------
  // Request and response qualification
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight  = {1'b0, outstanding_q} + {1'b0, fifo_count};
    credit_ok = inflight < DEPTH_W;
    // run_q keeps the request low in the first cycle out of reset
    imem.req  = run_q && !redirect && credit_ok && (discard_q == '0) && !fetch_block;
    imem.addr = fetch_pc_q;
    grant     = imem.req && imem.gnt;
    rsp_drop  = imem.rvalid && (discard_q != '0);
    // a response with nothing outstanding is a leftover from before reset
    rsp_take  = imem.rvalid && (discard_q == '0) && (outstanding_q != '0);
    rsp_pending = (discard_q != '0) || (outstanding_q != '0);
  end

  // ---------------------------------------------------------------------------
  // PC and counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect) begin
      fetch_pc_d    = word_align(redirect_pc);
      outstanding_d = '0;
      // everything still in flight, less a word returning this very cycle, must be dropped
      discard_d     = discard_q + outstanding_q - CW'(imem.rvalid && rsp_pending);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;
      outstanding_d = outstanding_q + CW'(grant) - CW'(rsp_take);
      if (rsp_drop) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      run_q         <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight pc queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcq_wptr_q <= '0;
      pcq_rptr_q <= '0;
    end else if (redirect) begin
      pcq_wptr_q <= '0;
      pcq_rptr_q <= '0;
    end else begin
      if (grant)    pcq_wptr_q <= pcq_wptr_q + AW'(1);
      if (rsp_take) pcq_rptr_q <= pcq_rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (grant) pcq_mem_q[pcq_wptr_q] <= fetch_pc_q;
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_push_data.inst = imem.rdata;
    fifo_push_data.pc   = pcq_mem_q[pcq_rptr_q];
    fifo_pop            = if_valid && if_ready;
  end

  fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (redirect),
    .push_i      (rsp_take),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Misaligned redirect handling
  // ---------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            mis_q, mis_d;
  logic            mis_pend_q, mis_pend_d;
  logic [XLEN-1:0] mis_pc_q, mis_pc_d;

  always_comb begin
    mis_d      = mis_q;
    mis_pend_d = mis_pend_q;
    mis_pc_d   = mis_pc_q;
    if (redirect) begin
      mis_d      = (redirect_pc[1:0] != 2'b00);
      mis_pend_d = (redirect_pc[1:0] != 2'b00);
      mis_pc_d   = redirect_pc;
    end else if (mis_pend_q && if_ready) begin
      mis_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q      <= 1'b0;
      mis_pend_q <= 1'b0;
      mis_pc_q   <= RESET_PC;
    end else begin
      mis_q      <= mis_d;
      mis_pend_q <= mis_pend_d;
      mis_pc_q   <= mis_pc_d;
    end
  end

  // sticky until the next redirect, even after decode has taken the marker NOP
  assign fetch_block = mis_q;
  assign if_misalign = mis_pend_q;
`else
  assign fetch_block = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Decode-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    if_valid = !fifo_empty;
    if_inst  = fifo_empty ? NOP_INST : fifo_head.inst;
    if_pc    = fifo_empty ? fetch_pc_q : fifo_head.pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (mis_pend_q) begin
      if_valid = 1'b1;
      if_inst  = NOP_INST;
      if_pc    = mis_pc_q;
    end
`endif
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a one-cycle-latency memory that returns rdata == addr,
// decode-side acceptance log, and hand-computed expected pcs per scenario.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_misalign;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_inst     (if_inst),
    .if_pc       (if_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .if_misalign (if_misalign)
`endif
  );

`ifndef FETCH_MISALIGN_CHECK_EN
  assign if_misalign = 1'b0;
`endif

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned grant_cnt = 0;
  int unsigned req_cnt = 0;
  logic        gnt_en = 1'b0, rsp_en = 1'b0, rdy = 1'b0, redir = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] pend[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pc_at(input int i);
    if (i < got_pc.size()) return got_pc[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] inst_at(input int i);
    if (i < got_inst.size()) return got_inst[i];
    return 32'hxxxx_xxxx;
  endfunction

  // One clock cycle: drive inputs at negedge, observe settled outputs, book the events that the
  // coming rising edge will commit. Outputs remain observable to the caller afterwards.
  task automatic tick();
    @(negedge clk);
    if (rsp_en && pend.size() != 0) begin
      bus.rvalid = 1'b1;
      bus.rdata  = pend[0];
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = '0;
    end
    bus.gnt     = gnt_en;
    if_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    if (bus.rvalid) void'(pend.pop_front());
    if (bus.req && bus.gnt) begin
      pend.push_back(bus.addr);
      grant_cnt++;
    end
    if (bus.req) req_cnt++;
    if (if_valid && if_ready && !redirect) begin
      got_pc.push_back(if_pc);
      got_inst.push_back(if_inst);
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redir = 1'b1;
    rpc   = pc;
    tick();
    redir = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset, then let any pre-reset responses trickle back; the DUT must ignore them.
  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    redirect   = 1'b0;
    if_ready   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    gnt_en = 1'b0;
    rsp_en = 1'b1;
    rdy    = 1'b0;
    redir  = 1'b0;
    for (int i = 0; i < 8 && pend.size() != 0; i++) tick();
    pend.delete();
    got_pc.delete();
    got_inst.delete();
    grant_cnt = 0;
    req_cnt   = 0;
  endtask

  task automatic wait_grants(input int unsigned n);
    for (int i = 0; i < 12 && grant_cnt < n; i++) tick();
  endtask

  initial begin
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;

    // Reset state
    apply_reset();
    check_eq("rst_req", bus.req, 1'b0);
    check_eq("rst_addr", bus.addr, 32'h0);
    check_eq("rst_valid", if_valid, 1'b0);
    check_eq("rst_inst", if_inst, 32'h0000_0013);
    check_eq("rst_pc", if_pc, 32'h0);

    // Sequential stream
    gnt_en = 1'b1; rsp_en = 1'b1; rdy = 1'b1;
    run(15);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("seq_pc%0d", i), pc_at(i), 32'(i * 4));
      check_eq($sformatf("seq_inst%0d", i), inst_at(i), 32'(i * 4));
    end

    // Decode back-pressure
    apply_reset();
    gnt_en = 1'b1; rsp_en = 1'b1; rdy = 1'b0;
    run(10);
    check_eq("bp_grants", grant_cnt, 32'd2);
    check_eq("bp_req_low", bus.req, 1'b0);
    check_eq("bp_valid", if_valid, 1'b1);
    check_eq("bp_head_pc", if_pc, 32'h0);
    rdy = 1'b1;
    run(12);
    for (int i = 0; i < 4; i++) check_eq($sformatf("bp_pc%0d", i), pc_at(i), 32'(i * 4));
    check_eq("bp_inst3", inst_at(3), 32'hC);

    // Redirect with two grants outstanding
    apply_reset();
    gnt_en = 1'b1; rsp_en = 1'b0; rdy = 1'b1;
    wait_grants(2);
    check_eq("rd_grants", grant_cnt, 32'd2);
    redirect_to(32'h100);
    check_eq("rd_req_low", bus.req, 1'b0);
    rsp_en = 1'b1;
    run(10);
    check_eq("rd_pc0", pc_at(0), 32'h100);
    check_eq("rd_inst0", inst_at(0), 32'h100);
    check_eq("rd_pc1", pc_at(1), 32'h104);

    // Redirect coinciding with rvalid and decode acceptance
    apply_reset();
    gnt_en = 1'b1; rsp_en = 1'b0; rdy = 1'b0;
    wait_grants(2);
    rsp_en = 1'b1;
    tick();
    rdy = 1'b1;
    redir = 1'b1; rpc = 32'h180;
    tick();
    redir = 1'b0;
    check_eq("rv_valid", if_valid, 1'b1);
    check_eq("rv_head_pc", if_pc, 32'h0);
    tick();
    check_eq("rv_resume_req", bus.req, 1'b1);
    check_eq("rv_resume_addr", bus.addr, 32'h180);
    run(8);
    check_eq("rv_pc0", pc_at(0), 32'h180);
    check_eq("rv_inst0", inst_at(0), 32'h180);
    check_eq("rv_pc1", pc_at(1), 32'h184);

    // Grant stall
    apply_reset();
    gnt_en = 1'b0; rsp_en = 1'b1; rdy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("st_req%0d", i), bus.req, 1'b1);
      check_eq($sformatf("st_addr%0d", i), bus.addr, 32'h0);
    end
    gnt_en = 1'b1;
    run(8);
    check_eq("st_pc0", pc_at(0), 32'h0);
    check_eq("st_pc1", pc_at(1), 32'h4);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect target
    apply_reset();
    gnt_en = 1'b0; rsp_en = 1'b1; rdy = 1'b0;
    tick();
    redirect_to(32'h102);
    gnt_en = 1'b1;
    tick();
    check_eq("ma_flag", if_misalign, 1'b1);
    check_eq("ma_valid", if_valid, 1'b1);
    check_eq("ma_pc", if_pc, 32'h102);
    check_eq("ma_inst", if_inst, 32'h0000_0013);
    req_cnt = 0;
    run(3);
    check_eq("ma_no_req", req_cnt, 32'd0);
    rdy = 1'b1;
    redirect_to(32'h200);
    run(8);
    check_eq("ma_clear", if_misalign, 1'b0);
    check_eq("ma_pc0", pc_at(0), 32'h200);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
